dac_spi_monitor: RTL and testbench
==================================

# dac_spi_monitor

Receive-side counterpart of the per-channel DAC serial link: samples one DAC's DAC_SYNC / DAC_SCLK / DAC_DIN lines in the dataclk domain and deserializes each 24-bit frame. Completed frames go into a small first-word-fall-through FIFO for loopback checking, host readback and on-chip verification of the DAC driver path. Malformed frames are flagged and discarded. One instance per DAC channel; it sits beside the DAC driver on the same dataclk.

## Interface
- FIFO_DEPTH, 4, number of stored frames; power of two, 2..16
- FIFO_AW, 2, log2(FIFO_DEPTH)
- dataclk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low: reset==0 at a dataclk rising edge resets the block
- DAC_SYNC  input  1  frame strobe, active low, driven by DAC driver in dataclk domain
- DAC_SCLK  input  1  serial clock; data taken on its falling edge
- DAC_DIN  input  1  serial data, MSB first
- rd_en  input  1  pop head entry; ignored when empty
- rd_data  output  24  head entry {ctrl[7:0], data[15:0]}; valid while empty==0
- rd_ctrl_nonzero  output  1  rd_data[23:16] != 0 (non-normal-mode frame)
- empty  output  1  FIFO holds no entry
- full  output  1  FIFO holds FIFO_DEPTH entries
- fifo_level  output  FIFO_AW+1  entries held, 0..FIFO_DEPTH
- frame_done  output  1  one-cycle pulse when a valid frame is pushed (or dropped on overflow)
- frame_error  output  1  one-cycle pulse on a short or long frame
- overflow  output  1  one-cycle pulse when a completed frame is dropped because FIFO full
- frame_count  output  16  completed valid frames since reset, wraps 0xFFFF->0

## Operation
- Input stage: s_sync, s_sclk, s_din registered every cycle; s_sclk_d holds previous s_sclk. Fall event = s_sclk_d & ~s_sclk. Reset value of s_sync/s_sclk/s_sclk_d is 1, s_din 0.
- States: IDLE, SHIFT, DONE.
- IDLE: bit_cnt=0. s_sync==0 -> SHIFT (a fall in that same cycle is shifted in).
- SHIFT: on fall, shreg <= {shreg[22:0], s_din}, bit_cnt+1. When bit_cnt reaches 24 -> DONE with complete word. s_sync==1 with bit_cnt 1..23 -> frame_error pulse, discard, IDLE. s_sync==1 with bit_cnt 0 -> IDLE silently.
- DONE (one cycle): push shreg to FIFO, frame_done pulse, frame_count+1; if full and no pop this cycle, drop word, overflow pulse, frame_count unchanged. Then WAIT_HIGH behaviour inside DONE-exit: state goes to IDLE only after s_sync==1; while waiting, first extra fall -> frame_error pulse once, extra bits ignored.
- SCLK falls while s_sync==1 ignored in all states.
- FIFO: circular, FIFO_AW-bit read/write pointers, separate level counter. Push and pop in same cycle: both happen, level unchanged (also when full). Pop when empty: no effect. rd_data shows head combinationally from storage; undefined-but-stable content when empty is not checked.
- Reset: FSM IDLE, bit_cnt 0, shreg 0, pointers 0, fifo_level 0, empty 1, full 0, all pulses 0, frame_count 0. Reset mid-frame discards partial word with no error pulse.

## Timing
- Pin-level SCLK low first sampled at edge N -> fall detected in cycle after N, bit shifted at edge N+1.
- 24th bit shifted at edge M -> DONE during cycle after M -> push at edge M+1: empty=0, fifo_level+1, frame_done=1 during cycle after M+1.
- DIN must be stable at the edge where SCLK low is first sampled; driver's SCLK half-period >= 1 dataclk guaranteed.
- rd_en at edge K -> head advances and fifo_level-1 visible after K.
- Error pulses issued one cycle after the offending sampled SYNC rise or extra fall.
- Minimum frame-to-frame spacing supported: SYNC high for 1 sampled cycle.

## Test plan
- Reset held 0 for 3 cycles -> empty=1, full=0, fifo_level=0, frame_count=0, no pulses.
- One frame 0x00_8123 (SCLK period 4 cycles) -> one frame_done, rd_data=0x008123, rd_ctrl_nonzero=0, frame_count=1; rd_en -> empty=1.
- Five back-to-back frames 0x000001..0x000005 with FIFO_DEPTH=4, no reads -> full=1 after 4th, overflow pulse on 5th, frame_count=4, reads return 1,2,3,4.
- SYNC raised after 13 bits -> frame_error pulse, fifo_level unchanged; following full frame 0x03_FFFF captured correctly with rd_ctrl_nonzero=1.
- 26 SCLK falls in one SYNC-low window of 0x00_AAAA + 2 bits -> word 0x00AAAA pushed, exactly one frame_error, no second push.
- Frame completes while full and rd_en asserted at push edge -> no overflow, fifo_level stays 4, new word at tail; reset pulled low mid-frame -> all outputs at reset values, next frame captured cleanly.

Source files
------------

// File: rtl/dac_spi_monitor.sv
// dac_spi_monitor: samples one DAC channel's SYNC/SCLK/DIN in the dataclk
// domain, deserializes 24-bit frames and queues them in a FWFT FIFO.
// Short/long frames raise frame_error; a frame completing while the FIFO
// is full (and not popped that cycle) is dropped with an overflow pulse.
module dac_spi_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               dataclk,
  input  logic               reset,
  input  logic               DAC_SYNC,
  input  logic               DAC_SCLK,
  input  logic               DAC_DIN,
  input  logic               rd_en,
  output logic [23:0]        rd_data,
  output logic               rd_ctrl_nonzero,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               frame_done,
  output logic               frame_error,
  output logic               overflow,
  output logic [15:0]        frame_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // bit_cnt doubles as the DONE sub-state: 24 = push pending,
  // 25 = waiting for SYNC high, 26 = extra fall already flagged.
  localparam logic [4:0] CNT_PUSH  = 5'd24;
  localparam logic [4:0] CNT_WAIT  = 5'd25;
  localparam logic [4:0] CNT_EXTRA = 5'd26;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic s_sync, s_sclk, s_sclk_d, s_din, fall;
  state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] shreg_q, shreg_d;
  logic push_req, err_d, do_pop, do_push;
  logic [23:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

  assign fall            = s_sclk_d & ~s_sclk;
  assign empty           = (fifo_level == '0);
  assign full            = (fifo_level == LVL_FULL);
  assign rd_data         = mem[rd_ptr];
  assign rd_ctrl_nonzero = |rd_data[23:16];
  assign do_pop          = rd_en & ~empty;
  assign do_push         = push_req & (~full | do_pop);

  // Register the serial lines; s_sclk_d gives the falling-edge detect.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      s_sync <= 1'b1; s_sclk <= 1'b1; s_sclk_d <= 1'b1; s_din <= 1'b0;
    end else begin
      s_sync <= DAC_SYNC; s_sclk <= DAC_SCLK; s_sclk_d <= s_sclk; s_din <= DAC_DIN;
    end
  end

  // Frame FSM state, bit counter and shift register.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      state_q <= IDLE; cnt_q <= '0; shreg_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; shreg_q <= shreg_d;
    end
  end

  // Next-state: shift on qualified falls, classify frame end.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!s_sync) begin
          state_d = SHIFT;
          if (fall) begin
            shreg_d = {shreg_q[22:0], s_din};
            cnt_d   = 5'd1;
          end
        end
      end
      SHIFT: begin
        if (s_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = (cnt_q != '0);
        end else if (fall) begin
          shreg_d = {shreg_q[22:0], s_din};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd23) state_d = DONE;
        end
      end
      DONE: begin
        push_req = (cnt_q == CNT_PUSH);
        if (cnt_q == CNT_PUSH) cnt_d = CNT_WAIT;
        if (s_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (fall && cnt_q != CNT_EXTRA) begin
          err_d = 1'b1;
          cnt_d = CNT_EXTRA;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO storage; no reset needed, content is only read while non-empty.
  always_ff @(posedge dataclk) begin
    if (do_push) mem[wr_ptr] <= shreg_q;
  end

  // FIFO pointers, level, frame counter and status pulses.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_level <= '0; frame_count <= '0;
      frame_done <= 1'b0; frame_error <= 1'b0; overflow <= 1'b0;
    end else begin
      frame_done  <= push_req;
      overflow    <= push_req & ~do_push;
      frame_error <= err_d;
      if (do_push) begin
        wr_ptr      <= wr_ptr + PTR_ONE;
        frame_count <= frame_count + 16'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      fifo_level <= fifo_level + LVL_ONE;
      else if (!do_push && do_pop) fifo_level <= fifo_level - LVL_ONE;
    end
  end

endmodule

// File: tb/tb_dac_spi_monitor.sv
// Directed bench for dac_spi_monitor: drives SYNC/SCLK/DIN frames and checks
// FIFO contents, status flags and pulse counts against hand-computed values.
module tb_dac_spi_monitor;
  logic dataclk = 1'b0, reset = 1'b0;
  logic DAC_SYNC = 1'b1, DAC_SCLK = 1'b1, DAC_DIN = 1'b0, rd_en = 1'b0;
  logic [23:0] rd_data;
  logic rd_ctrl_nonzero, empty, full, frame_done, frame_error, overflow;
  logic [2:0] fifo_level;
  logic [15:0] frame_count;

  int checks = 0, failures = 0;
  int cyc = 0, n_done = 0, n_err = 0, n_ovf = 0, done_cyc = -1, last_fall_cyc = 0;
  int b_done, b_err, b_ovf;

  dac_spi_monitor #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .dataclk(dataclk), .reset(reset), .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK),
    .DAC_DIN(DAC_DIN), .rd_en(rd_en), .rd_data(rd_data),
    .rd_ctrl_nonzero(rd_ctrl_nonzero), .empty(empty), .full(full),
    .fifo_level(fifo_level), .frame_done(frame_done), .frame_error(frame_error),
    .overflow(overflow), .frame_count(frame_count)
  );

  always #5 dataclk = ~dataclk;

  // Edge counter and pulse monitor (sampled on the falling edge).
  always @(posedge dataclk) cyc++;
  always @(negedge dataclk) begin
    if (frame_done) begin n_done++; done_cyc = cyc; end
    if (frame_error) n_err++;
    if (overflow) n_ovf++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge dataclk); #1; end
  endtask

  task automatic apply_reset();
    reset = 1'b0; DAC_SYNC = 1'b1; DAC_SCLK = 1'b1; DAC_DIN = 1'b0; rd_en = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic snap();
    b_done = n_done; b_err = n_err; b_ovf = n_ovf;
  endtask

  // MSB-first bits, SCLK period 4 cycles; optionally pop at the push edge.
  task automatic send_bits(input logic [31:0] val, input int nbits, input bit pop_last);
    for (int i = nbits - 1; i >= 0; i--) begin
      DAC_DIN = val[i]; DAC_SCLK = 1'b1;
      tick(2);
      DAC_SCLK = 1'b0; last_fall_cyc = cyc;
      tick(2);
      if (pop_last && i == 0) rd_en = 1'b1;
    end
    DAC_SCLK = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(1);
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits, input bit pop_last);
    DAC_SYNC = 1'b0;
    tick(1);
    send_bits(val, nbits, pop_last);
    DAC_SYNC = 1'b1;
    tick(1);
  endtask

  task automatic pop();
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    checks++; if ({frame_done, frame_error, overflow} !== 3'b000) begin failures++;
      $display("FAIL reset_pulses got=%b exp=000", {frame_done, frame_error, overflow}); end
  endtask

  task automatic test_single();
    apply_reset(); snap();
    send_frame(32'h008123, 24, 1'b0);
    tick(3);
    checks++; if (n_done - b_done != 1) begin failures++; $display("FAIL single_done got=%0d exp=1", n_done - b_done); end
    checks++; if (done_cyc != last_fall_cyc + 3) begin failures++;
      $display("FAIL single_latency got=%0d exp=%0d", done_cyc, last_fall_cyc + 3); end
    checks++; if (rd_data !== 24'h008123) begin failures++; $display("FAIL single_data got=%h exp=008123", rd_data); end
    checks++; if (rd_ctrl_nonzero !== 1'b0) begin failures++; $display("FAIL single_ctrl got=%b exp=0", rd_ctrl_nonzero); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", frame_count); end
    checks++; if (n_err != b_err) begin failures++; $display("FAIL single_err got=%0d exp=0", n_err - b_err); end
    pop();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    apply_reset(); snap();
    for (int k = 1; k <= 4; k++) send_frame(32'(k), 24, 1'b0);
    tick(1);
    checks++; if (full !== 1'b1 || fifo_level !== 3'd4) begin failures++;
      $display("FAIL b2b_full got=%b/%0d exp=1/4", full, fifo_level); end
    send_frame(32'd5, 24, 1'b0);
    tick(3);
    checks++; if (n_ovf - b_ovf != 1) begin failures++; $display("FAIL b2b_overflow got=%0d exp=1", n_ovf - b_ovf); end
    checks++; if (n_done - b_done != 5) begin failures++; $display("FAIL b2b_done got=%0d exp=5", n_done - b_done); end
    checks++; if (frame_count !== 16'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", frame_count); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (rd_data !== 24'(k)) begin failures++; $display("FAIL b2b_read%0d got=%h exp=%h", k, rd_data, 24'(k)); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_drain got=%b exp=1", empty); end
  endtask

  task automatic test_short_frame();
    apply_reset(); snap();
    send_frame(32'h1ABC, 13, 1'b0);
    tick(3);
    checks++; if (n_err - b_err != 1) begin failures++; $display("FAIL short_err got=%0d exp=1", n_err - b_err); end
    checks++; if (fifo_level !== 3'd0 || n_done != b_done) begin failures++;
      $display("FAIL short_level got=%0d exp=0", fifo_level); end
    send_frame(32'h03FFFF, 24, 1'b0);
    tick(3);
    checks++; if (rd_data !== 24'h03FFFF) begin failures++; $display("FAIL short_next_data got=%h exp=03ffff", rd_data); end
    checks++; if (rd_ctrl_nonzero !== 1'b1) begin failures++; $display("FAIL short_next_ctrl got=%b exp=1", rd_ctrl_nonzero); end
  endtask

  task automatic test_long_frame();
    apply_reset(); snap();
    send_frame({6'd0, 24'h00AAAA, 2'b11}, 26, 1'b0);
    tick(3);
    checks++; if (n_err - b_err != 1) begin failures++; $display("FAIL long_err got=%0d exp=1", n_err - b_err); end
    checks++; if (n_done - b_done != 1 || fifo_level !== 3'd1) begin failures++;
      $display("FAIL long_push got=%0d/%0d exp=1/1", n_done - b_done, fifo_level); end
    checks++; if (rd_data !== 24'h00AAAA) begin failures++; $display("FAIL long_data got=%h exp=00aaaa", rd_data); end
  endtask

  task automatic test_full_pop_and_reset();
    apply_reset();
    for (int k = 1; k <= 4; k++) send_frame(32'(k), 24, 1'b0);
    snap();
    send_frame(32'h0000AB, 24, 1'b1);
    tick(3);
    checks++; if (n_ovf != b_ovf) begin failures++; $display("FAIL fullpop_ovf got=%0d exp=0", n_ovf - b_ovf); end
    checks++; if (fifo_level !== 3'd4 || full !== 1'b1) begin failures++;
      $display("FAIL fullpop_level got=%0d exp=4", fifo_level); end
    checks++; if (frame_count !== 16'd5) begin failures++; $display("FAIL fullpop_count got=%0d exp=5", frame_count); end
    for (int k = 2; k <= 5; k++) begin
      checks++; if (rd_data !== ((k == 5) ? 24'h0000AB : 24'(k))) begin failures++;
        $display("FAIL fullpop_read%0d got=%h", k, rd_data); end
      pop();
    end
    // Reset in the middle of a frame.
    snap();
    DAC_SYNC = 1'b0; tick(1);
    send_bits(32'h3FF, 10, 1'b0);
    reset = 1'b0; tick(2); reset = 1'b1; tick(1);
    checks++; if (fifo_level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || frame_count !== 16'd0) begin failures++;
      $display("FAIL midreset_state got=%0d/%b/%b/%0d exp=0/1/0/0", fifo_level, empty, full, frame_count); end
    DAC_SYNC = 1'b1; tick(2);
    send_frame(32'h5A5A5A, 24, 1'b0);
    tick(3);
    checks++; if (rd_data !== 24'h5A5A5A || fifo_level !== 3'd1) begin failures++;
      $display("FAIL midreset_next got=%h/%0d exp=5a5a5a/1", rd_data, fifo_level); end
    checks++; if (n_err != b_err) begin failures++; $display("FAIL midreset_err got=%0d exp=0", n_err - b_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_full_pop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
